// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC, imem request issue, response FIFO, decode handshake.
// Optional combinational response bypass when FETCH_BYPASS_EN is defined.
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_d,
  input  logic        ready_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_ent_t;

  fq_ent_t       r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc;
  logic [31:0]   r_ipc;
  logic          r_inf;

  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_empty;
  logic          w_live;
  logic          w_byp;
  logic          w_valid;
  logic          w_pop;
  logic          w_enq;
  fq_ent_t       w_resp;
  fq_ent_t       w_head;
  logic          w_unused;

  assign w_unused = ^redirect_pc[1:0];

  // Reserve a slot for every outstanding read before issuing another.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inf};
  assign w_req   = !rst && !redirect && (w_occ < DEPTH_W);
  assign w_empty = (r_count == '0);
  assign w_live  = r_inf && !redirect && !rst;
  assign w_resp  = '{instr: imem_rdata, pc: r_ipc};

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_empty && w_live;
`else
  assign w_byp = 1'b0;
`endif

  assign w_head  = w_byp ? w_resp : r_mem[r_rd];
  assign w_valid = !rst && (!w_empty || w_byp);
  assign w_pop   = w_valid && ready_d && !redirect && !w_empty;
  assign w_enq   = w_live && !(w_byp && ready_d);

  assign imem_req  = w_req;
  assign imem_addr = rst ? 32'h0 : r_pc;
  assign valid_d   = w_valid;
  assign instr_d   = rst ? 32'h0 : w_head.instr;
  assign pc_d      = rst ? 32'h0 : w_head.pc;
  assign pcplus4_d = pc_d + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_ipc   <= '0;
      r_inf   <= 1'b0;
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else if (redirect) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_inf   <= 1'b0;
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      if (w_req) begin
        r_pc  <= r_pc + 32'd4;
        r_ipc <= r_pc;
      end
      r_inf <= w_req;
      if (w_enq) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr] <= w_resp;
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage with a queue-based reference model.
module tb_fetch_queue_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] WPC   = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready_d = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pcplus4_d;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_instr, w_pc, w_pc4;

  int n_chk = 0;
  int n_pass = 0;

  fetch_queue_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .valid_d(valid_d), .ready_d(ready_d),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d)
  );

  fetch_queue_stage #(.RESET_PC(WPC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .valid_d(w_valid), .ready_d(1'b1),
    .instr_d(w_instr), .pc_d(w_pc), .pcplus4_d(w_pc4)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a holds a>>2; junk when idle.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr >> 2) : $urandom;
    w_rdata    <= w_req ? (w_addr >> 2) : $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference model and per-cycle comparison.
  initial begin
    ent_t        q[$];
    ent_t        hd;
    logic [31:0] m_pc, m_ipc;
    bit          m_inf, e_req, e_valid, byp, n_set;
    int          cyc, n_rel;
    m_pc = RPC; m_ipc = '0; m_inf = 0; n_set = 0; cyc = 0; n_rel = 0;
    forever begin
      @(negedge clk);
      e_req = !rst && !redirect && (q.size() + int'(m_inf) < DEPTH);
      byp = BYP && q.size() == 0 && m_inf && !redirect && !rst;
      e_valid = !rst && (q.size() != 0 || byp);
      if (q.size() != 0) hd = q[0];
      else hd = '{instr: m_ipc >> 2, pc: m_ipc};
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (rst) chk("imem_addr_rst", imem_addr, 32'h0);
      else if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk("valid_d", 32'(valid_d), 32'(e_valid));
      if (e_valid) begin
        chk("instr_d", instr_d, hd.instr);
        chk("pc_d", pc_d, hd.pc);
        chk("pcplus4_d", pcplus4_d, hd.pc + 32'd4);
      end
      if (rst) begin
        chk("instr_d_rst", instr_d, 32'h0);
        chk("pc_d_rst", pc_d, 32'h0);
      end
      if (!n_set && !rst) begin
        n_set = 1; n_rel = cyc;
      end
      if (n_set && cyc == n_rel) begin
        chk("lit_first_req", 32'(imem_req), 32'd1);
        chk("lit_first_addr", imem_addr, RPC);
      end
      if (n_set && cyc == n_rel + LAT - 1)
        chk("lit_pre_valid", 32'(valid_d), 32'd0);
      if (n_set && cyc == n_rel + LAT) begin
        chk("lit_valid", 32'(valid_d), 32'd1);
        chk("lit_instr0", instr_d, 32'd0);
      end
      if (n_set && cyc == n_rel + LAT + 1) begin
        chk("lit_instr1", instr_d, 32'd1);
        chk("lit_pc1", pc_d, 32'd4);
        chk("lit_pc4_1", pcplus4_d, 32'd8);
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete(); m_pc = RPC; m_inf = 0;
      end else if (redirect) begin
        q.delete(); m_pc = redirect_pc & ~32'h3; m_inf = 0;
      end else begin
        if (e_valid && ready_d && q.size() != 0) void'(q.pop_front());
        if (m_inf && !(byp && ready_d))
          q.push_back('{instr: m_ipc >> 2, pc: m_ipc});
        if (e_req) begin
          m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
        m_inf = e_req;
      end
    end
  end

  // Wrap-around literals on the second instance.
  initial begin
    logic [31:0] a[3];
    int k, b;
    bit seen;
    k = 0; b = 0; seen = 0;
    a[0] = '0; a[1] = '0; a[2] = '0;
    do begin
      @(negedge clk); b++;
    end while (rst && b < 20);
    if (rst) chk("wrap_release", 32'(rst), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (w_req && k < 3) begin
        a[k] = w_addr; k++;
      end
      if (w_valid && w_pc == 32'hFFFF_FFFC) begin
        chk("wrap_pcplus4", w_pc4, 32'h0);
        seen = 1;
      end
      @(negedge clk);
    end
    chk("wrap_addr0", a[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", a[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", a[2], 32'h0000_0000);
    chk("wrap_seen", 32'(seen), 32'd1);
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1; ready_d = 1; redirect = 0;
    repeat (3) step();
    rst = 0;
    repeat (3) step();
    ready_d = 0;
    repeat (10) step();
    ready_d = 1;
    repeat (4) step();
    ready_d = 0; redirect = 1; redirect_pc = 32'h40;
    step();
    redirect = 0;
    repeat (4) step();
    redirect = 1; redirect_pc = 32'h100;
    step();
    redirect = 0;
    @(negedge clk);
    chk("redir_valid", 32'(valid_d), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    step();
    ready_d = 1;
    repeat (6) step();
    redirect = 1; redirect_pc = 32'h203;
    @(negedge clk);
    chk("redir_pop_valid", 32'(valid_d), 32'd1);
    step();
    redirect = 0;
    @(negedge clk);
    chk("redir2_addr", imem_addr, 32'h200);
    chk("redir2_valid", 32'(valid_d), 32'd0);
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", 32'(valid_d), 32'd0);
    for (int i = 0; i < 800; i++) begin
      step();
      ready_d = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ?
                    (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end
    step();
    rst = 0; redirect = 0; ready_d = 1;
    repeat (10) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
